// File: rtl/cic_pkg.sv
// Shared types, legal-parameter constants and the output-reduction helper for the CIC comb slice.
// Define CIC_COMB_ROUND_EN for round-half-up reduction with positive saturation; default is truncation.
package cic_pkg;

    localparam int MAX_WIDTH      = 64;
    localparam int DIFF_DELAY_MIN = 1;
    localparam int DIFF_DELAY_MAX = 2;

    // Widest sample the slice handles; narrower samples are sign-extended into it.
    typedef logic signed [MAX_WIDTH-1:0] wide_sample_t;

    // Result is sign-extended; callers keep the low out_width bits.
    function automatic wide_sample_t reduce_sample(input wide_sample_t value,
                                                   input int width,
                                                   input int out_width);
        int shift;
`ifdef CIC_COMB_ROUND_EN
        wide_sample_t rounded;
        wide_sample_t max_pos;
`endif
        shift = width - out_width;
`ifdef CIC_COMB_ROUND_EN
        if (shift == 0) begin
            return value;
        end
        rounded = (value + (wide_sample_t'(1) <<< (shift - 1))) >>> shift;
        max_pos = (wide_sample_t'(1) <<< (out_width - 1)) - wide_sample_t'(1);
        return (rounded > max_pos) ? max_pos : rounded;
`else
        return value >>> shift;
`endif
    endfunction

endpackage

// File: rtl/cic_comb_if.sv
// Sample stream into and out of the comb section: strobed input sample and strobed reduced output.
interface cic_comb_if #(
    parameter int WIDTH     = 16,
    parameter int OUT_WIDTH = 12
);

    logic signed [WIDTH-1:0]     in;
    logic                        in_valid;
    logic signed [OUT_WIDTH-1:0] out;
    logic                        out_valid;

    modport master (
        output in,
        output in_valid,
        input  out,
        input  out_valid
    );

    modport slave (
        input  in,
        input  in_valid,
        output out,
        output out_valid
    );

endinterface

// File: rtl/cic_comb_stage.sv
// One comb stage y[n] = x[n] - x[n-M] with an M-deep delay line; n counts valid samples, not cycles.
module cic_comb_stage #(
    parameter int WIDTH      = 16,
    parameter int DIFF_DELAY = 1
) (
    input  logic                    clk_slow,
    input  logic                    rstn,
    input  logic signed [WIDTH-1:0] x,
    input  logic                    x_valid,
    output logic signed [WIDTH-1:0] y,
    output logic                    y_valid
);

    logic signed [WIDTH-1:0] delay_line [DIFF_DELAY];

    // Data and history move only on valid samples, so input gaps leave the sequence intact.
    always_ff @(posedge clk_slow or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DIFF_DELAY; i++) begin
                delay_line[i] <= '0;
            end
            y       <= '0;
            y_valid <= 1'b0;
        end else begin
            y_valid <= x_valid;
            if (x_valid) begin
                y             <= x - delay_line[DIFF_DELAY-1];
                delay_line[0] <= x;
                for (int i = 1; i < DIFF_DELAY; i++) begin
                    delay_line[i] <= delay_line[i-1];
                end
            end
        end
    end

endmodule

// File: rtl/cic_comb.sv
// CIC decimator comb section: STAGES cascaded comb stages followed by a registered width reduction.
// Reduction mode is selected by CIC_COMB_ROUND_EN (see cic_pkg).
module cic_comb
    import cic_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int STAGES     = 3,
    parameter int DIFF_DELAY = 1,
    parameter int OUT_WIDTH  = 12
) (
    input logic       clk_slow,
    input logic       rstn,
    cic_comb_if.slave bus
);

    if (STAGES < 1 || DIFF_DELAY < DIFF_DELAY_MIN || DIFF_DELAY > DIFF_DELAY_MAX ||
        OUT_WIDTH < 2 || OUT_WIDTH > WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_params
        $fatal(1, "cic_comb: illegal parameter combination");
    end

    logic signed [WIDTH-1:0] stage_data [STAGES+1];
    logic [STAGES:0]         stage_valid;

    assign stage_data[0]  = bus.in;
    assign stage_valid[0] = bus.in_valid;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        cic_comb_stage #(
            .WIDTH      (WIDTH),
            .DIFF_DELAY (DIFF_DELAY)
        ) u_stage (
            .clk_slow (clk_slow),
            .rstn     (rstn),
            .x        (stage_data[k]),
            .x_valid  (stage_valid[k]),
            .y        (stage_data[k+1]),
            .y_valid  (stage_valid[k+1])
        );
    end

    // Output register holds its value between strobes.
    always_ff @(posedge clk_slow or negedge rstn) begin
        if (!rstn) begin
            bus.out       <= '0;
            bus.out_valid <= 1'b0;
        end else begin
            bus.out_valid <= stage_valid[STAGES];
            if (stage_valid[STAGES]) begin
                bus.out <= OUT_WIDTH'(reduce_sample(wide_sample_t'(stage_data[STAGES]), WIDTH, OUT_WIDTH));
            end
        end
    end

endmodule

// File: tb/tb_cic_comb.sv
// Bench for cic_comb: six parameterisations checked every cycle against a binomial-expansion model,
// plus directed sequences with hand-computed values and output cycles.
module tb_cic_comb;

    localparam int NDUT = 6;
    localparam int P_W    [NDUT] = '{16, 8, 8, 8, 8, 10};
    localparam int P_N    [NDUT] = '{3, 1, 2, 2, 1, 2};
    localparam int P_M    [NDUT] = '{1, 1, 1, 2, 1, 2};
    localparam int P_OW   [NDUT] = '{12, 8, 8, 8, 6, 7};
    localparam bit P_RAND [NDUT] = '{1, 0, 1, 1, 0, 1};

    typedef struct {
        longint val;
        int     cyc;
    } lit_t;

    logic   clk = 1'b0;
    logic   rstn = 1'b0;
    longint din     [NDUT];
    bit     dval    [NDUT];
    longint obs_out [NDUT];
    logic   obs_v   [NDUT];

    longint hist     [NDUT][$];
    bit     vq       [NDUT][$];
    lit_t   exp_lit  [NDUT][$];
    int     outcnt   [NDUT];
    longint last_out [NDUT];
    int     cyc = 0;
    int     n_checks = 0;
    int     n_fail = 0;
    bit     final_req = 1'b0;
    bit     final_done = 1'b0;

    always #5 clk = ~clk;

    cic_comb_if #(.WIDTH(16), .OUT_WIDTH(12)) if0 ();
    cic_comb_if #(.WIDTH(8),  .OUT_WIDTH(8))  if1 ();
    cic_comb_if #(.WIDTH(8),  .OUT_WIDTH(8))  if2 ();
    cic_comb_if #(.WIDTH(8),  .OUT_WIDTH(8))  if3 ();
    cic_comb_if #(.WIDTH(8),  .OUT_WIDTH(6))  if4 ();
    cic_comb_if #(.WIDTH(10), .OUT_WIDTH(7))  if5 ();

    cic_comb #(.WIDTH(16), .STAGES(3), .DIFF_DELAY(1), .OUT_WIDTH(12)) u_dut0 (.clk_slow(clk), .rstn(rstn), .bus(if0));
    cic_comb #(.WIDTH(8),  .STAGES(1), .DIFF_DELAY(1), .OUT_WIDTH(8))  u_dut1 (.clk_slow(clk), .rstn(rstn), .bus(if1));
    cic_comb #(.WIDTH(8),  .STAGES(2), .DIFF_DELAY(1), .OUT_WIDTH(8))  u_dut2 (.clk_slow(clk), .rstn(rstn), .bus(if2));
    cic_comb #(.WIDTH(8),  .STAGES(2), .DIFF_DELAY(2), .OUT_WIDTH(8))  u_dut3 (.clk_slow(clk), .rstn(rstn), .bus(if3));
    cic_comb #(.WIDTH(8),  .STAGES(1), .DIFF_DELAY(1), .OUT_WIDTH(6))  u_dut4 (.clk_slow(clk), .rstn(rstn), .bus(if4));
    cic_comb #(.WIDTH(10), .STAGES(2), .DIFF_DELAY(2), .OUT_WIDTH(7))  u_dut5 (.clk_slow(clk), .rstn(rstn), .bus(if5));

    assign if0.in = din[0][15:0];  assign if0.in_valid = dval[0];
    assign if1.in = din[1][7:0];   assign if1.in_valid = dval[1];
    assign if2.in = din[2][7:0];   assign if2.in_valid = dval[2];
    assign if3.in = din[3][7:0];   assign if3.in_valid = dval[3];
    assign if4.in = din[4][7:0];   assign if4.in_valid = dval[4];
    assign if5.in = din[5][9:0];   assign if5.in_valid = dval[5];

    assign obs_out[0] = longint'(if0.out);  assign obs_v[0] = if0.out_valid;
    assign obs_out[1] = longint'(if1.out);  assign obs_v[1] = if1.out_valid;
    assign obs_out[2] = longint'(if2.out);  assign obs_v[2] = if2.out_valid;
    assign obs_out[3] = longint'(if3.out);  assign obs_v[3] = if3.out_valid;
    assign obs_out[4] = longint'(if4.out);  assign obs_v[4] = if4.out_valid;
    assign obs_out[5] = longint'(if5.out);  assign obs_v[5] = if5.out_valid;

    function automatic longint wrap(longint v, int w);
        longint m;
        m = v & ((longint'(1) <<< w) - 1);
        if (m[w-1]) m = m - (longint'(1) <<< w);
        return m;
    endfunction

    function automatic longint binom(int n, int k);
        longint r = 1;
        for (int j = 0; j < k; j++) r = r * (n - j) / (j + 1);
        return r;
    endfunction

    function automatic longint reduce_model(longint v, int w, int ow);
        int     s;
        longint r;
        s = w - ow;
        if (s == 0) return v;
`ifdef CIC_COMB_ROUND_EN
        r = (v + (longint'(1) <<< (s - 1))) >>> s;
        if (r > (longint'(1) <<< (ow - 1)) - 1) r = (longint'(1) <<< (ow - 1)) - 1;
`else
        r = v >>> s;
`endif
        return r;
    endfunction

    // N cascaded combs of delay M equal the binomial expansion of (1 - z^-M)^N, taken mod 2^W.
    function automatic longint model_out(int i, int k);
        longint acc = 0;
        int     idx;
        for (int j = 0; j <= P_N[i]; j++) begin
            idx = k - j * P_M[i];
            if (idx >= 0) acc += ((j % 2 == 1) ? -1 : 1) * binom(P_N[i], j) * hist[i][idx];
        end
        return reduce_model(wrap(acc, P_W[i]), P_W[i], P_OW[i]);
    endfunction

    task automatic check_output(string name, longint act, longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NDUT; i++) begin
                hist[i].delete();
                vq[i].delete();
            end
        end else begin
            for (int i = 0; i < NDUT; i++) begin
                vq[i].push_back(dval[i]);
                if (vq[i].size() > 8) void'(vq[i].pop_front());
                if (dval[i]) hist[i].push_back(wrap(din[i], P_W[i]));
            end
        end
    end

    always @(negedge clk) begin
        bit     exp_v;
        longint exp_o;
        lit_t   lit;
        for (int i = 0; i < NDUT; i++) begin
            if (!rstn) begin
                check_output($sformatf("reset_out dut%0d", i), obs_out[i], 0);
                check_output($sformatf("reset_valid dut%0d", i), longint'(obs_v[i]), 0);
                outcnt[i]   = 0;
                last_out[i] = 0;
            end else begin
                exp_v = (vq[i].size() > P_N[i]) ? vq[i][vq[i].size() - 1 - P_N[i]] : 1'b0;
                check_output($sformatf("out_valid dut%0d", i), longint'(obs_v[i]), longint'(exp_v));
                if (exp_v) begin
                    exp_o       = model_out(i, outcnt[i]);
                    outcnt[i]   = outcnt[i] + 1;
                    last_out[i] = exp_o;
                end else begin
                    exp_o = last_out[i];
                end
                check_output($sformatf("out dut%0d", i), obs_out[i], exp_o);
                if (obs_v[i] === 1'b1 && exp_lit[i].size() > 0) begin
                    lit = exp_lit[i].pop_front();
                    check_output($sformatf("literal_value dut%0d", i), obs_out[i], lit.val);
                    check_output($sformatf("literal_cycle dut%0d", i), longint'(cyc), longint'(lit.cyc));
                end
            end
        end
        if (final_req && !final_done) begin
            for (int i = 0; i < NDUT; i++) begin
                check_output($sformatf("literal_drain dut%0d", i), longint'(exp_lit[i].size()), 0);
            end
            final_done = 1'b1;
        end
    end

    task automatic reset_all();
        @(negedge clk);
        #1 rstn = 1'b0;
        for (int i = 0; i < NDUT; i++) begin
            din[i]  = 0;
            dval[i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
    endtask

    // Called at a negedge; lat is the hand-computed cycle distance to the matching out_valid.
    task automatic apply_stimulus(int i, longint val, bit has_lit, longint lit_val, int lat);
        lit_t e;
        din[i]  = val;
        dval[i] = 1'b1;
        if (has_lit) begin
            e.val = lit_val;
            e.cyc = cyc + lat;
            exp_lit[i].push_back(e);
        end
        @(negedge clk);
        dval[i] = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < NDUT; i++) begin
            din[i]  = 0;
            dval[i] = 1'b0;
        end
        reset_all();

        $display("[TB] back-to-back 5,7,7,10 on one stage");
        apply_stimulus(1, 5, 1, 5, 2);
        apply_stimulus(1, 7, 1, 2, 2);
        apply_stimulus(1, 7, 1, 0, 2);
        apply_stimulus(1, 10, 1, 3, 2);
        idle(6);

        $display("[TB] same samples with 3-cycle gaps");
        reset_all();
        apply_stimulus(1, 5, 1, 5, 2);   idle(3);
        apply_stimulus(1, 7, 1, 2, 2);   idle(3);
        apply_stimulus(1, 7, 1, 0, 2);   idle(3);
        apply_stimulus(1, 10, 1, 3, 2);
        idle(6);

        $display("[TB] wrap-around 0x7F then 0x80");
        reset_all();
        apply_stimulus(1, 'h7F, 1, 127, 2);
        apply_stimulus(1, 'h80, 1, 1, 2);
        idle(6);

        $display("[TB] impulse responses, M=1 and M=2");
        reset_all();
        apply_stimulus(2, 1, 1, 1, 3);
        apply_stimulus(2, 0, 1, -2, 3);
        apply_stimulus(2, 0, 1, 1, 3);
        apply_stimulus(2, 0, 1, 0, 3);
        apply_stimulus(2, 0, 1, 0, 3);
        apply_stimulus(3, 1, 1, 1, 3);
        apply_stimulus(3, 0, 1, 0, 3);
        apply_stimulus(3, 0, 1, -2, 3);
        apply_stimulus(3, 0, 1, 0, 3);
        apply_stimulus(3, 0, 1, 1, 3);
        apply_stimulus(3, 0, 1, 0, 3);
        idle(6);

        $display("[TB] width reduction 8 -> 6");
        reset_all();
`ifdef CIC_COMB_ROUND_EN
        apply_stimulus(4, 6, 1, 2, 2);
`else
        apply_stimulus(4, 6, 1, 1, 2);
`endif
        idle(4);
        reset_all();
`ifdef CIC_COMB_ROUND_EN
        apply_stimulus(4, -6, 1, -1, 2);
`else
        apply_stimulus(4, -6, 1, -2, 2);
`endif
        idle(4);
        reset_all();
        apply_stimulus(4, 127, 1, 31, 2);
        idle(4);

        $display("[TB] reset mid-stream");
        reset_all();
        apply_stimulus(1, 5, 1, 5, 2);
        apply_stimulus(1, 7, 1, 2, 2);
        apply_stimulus(1, 7, 0, 0, 2);
        #1 rstn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 rstn = 1'b1;
        idle(4);
        apply_stimulus(1, 4, 1, 4, 2);
        idle(6);

        $display("[TB] randomized streams with gaps");
        reset_all();
        for (int t = 0; t < 600; t++) begin
            for (int i = 0; i < NDUT; i++) begin
                if (P_RAND[i]) begin
                    dval[i] = ($urandom_range(0, 3) != 0);
                    din[i]  = longint'($urandom);
                end
            end
            @(negedge clk);
            if (t == 300) begin
                #1 rstn = 1'b0;
                @(negedge clk);
                #1 rstn = 1'b1;
            end
        end
        for (int i = 0; i < NDUT; i++) dval[i] = 1'b0;
        idle(8);

        final_req = 1'b1;
        repeat (3) @(negedge clk);
        if (!final_done) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL final_drain: got not-run, expected run");
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
